// File: rtl/rtc_lectura_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_lectura_ctrl
//  Description : Periodic reader of the nine RTC time/date/timer registers over
//                a multiplexed AD bus; publishes a coherent BCD snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_lectura_ctrl #(
    parameter int T_FASE     = 10,
    parameter int T_REFRESCO = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       pausa,
    input  logic       leer_ya,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] ano,
    output logic [7:0] t_seg,
    output logic [7:0] t_min,
    output logic [7:0] t_hora,
    output logic       dato_valido,
    output logic       error_bcd,
    output logic       ocupado
);

    localparam int c_REF_W  = (T_REFRESCO > 1) ? $clog2(T_REFRESCO) : 1;
    localparam int c_FASE_W = (T_FASE > 1) ? $clog2(T_FASE) : 1;
    localparam logic [c_REF_W-1:0]  c_REF_MAX  = c_REF_W'(T_REFRESCO - 1);
    localparam logic [c_FASE_W-1:0] c_FASE_MAX = c_FASE_W'(T_FASE - 1);
    localparam logic [3:0]          c_IDX_ULT  = 4'd8;

    typedef enum logic [3:0] {
        ESPERA = 4'd0,
        A_SET  = 4'd1,
        A_STB  = 4'd2,
        A_HLD  = 4'd3,
        GAP    = 4'd4,
        D_SET  = 4'd5,
        D_STB  = 4'd6,
        D_HLD  = 4'd7,
        FIN    = 4'd8
    } estado_t;

    estado_t               r_estado;
    estado_t               w_estado_sig;
    logic [c_FASE_W-1:0]   r_fase;
    logic [3:0]            r_idx;
    logic [c_REF_W-1:0]    r_refresco;
    logic [7:0]            r_sombra [0:8];

    logic                  w_fase_fin;
    logic                  w_refresco_fin;
    logic                  w_arranque;
    logic                  w_bcd_ok;
    logic [7:0]            w_dir;
    logic                  w_cs_n;
    logic                  w_rd_n;
    logic                  w_wr_n;
    logic                  w_a_d;
    logic                  w_ad_oe;
    logic [7:0]            w_ad_out;

    assign w_fase_fin     = (r_fase == c_FASE_MAX);
    assign w_refresco_fin = (r_refresco == c_REF_MAX);
    assign w_arranque     = (w_refresco_fin || leer_ya) && !pausa;
    assign w_bcd_ok       = (ad_in[7:4] <= 4'd9) && (ad_in[3:0] <= 4'd9);
    // Indices 0..5 map to 0x21..0x26, indices 6..8 to the timer block 0x41..0x43
    assign w_dir          = (r_idx < 4'd6) ? (8'h21 + {4'd0, r_idx})
                                           : (8'h41 + {4'd0, r_idx} - 8'd6);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            ESPERA:  if (w_arranque) w_estado_sig = A_SET;
            A_SET:   w_estado_sig = A_STB;
            A_STB:   if (w_fase_fin) w_estado_sig = A_HLD;
            A_HLD:   w_estado_sig = GAP;
            GAP:     w_estado_sig = D_SET;
            D_SET:   w_estado_sig = D_STB;
            D_STB:   if (w_fase_fin) w_estado_sig = D_HLD;
            D_HLD:   w_estado_sig = (r_idx == c_IDX_ULT) ? FIN : A_SET;
            FIN:     w_estado_sig = ESPERA;
            default: w_estado_sig = ESPERA;
        endcase
    end

    always_comb begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_a_d    = 1'b0;
        w_ad_oe  = 1'b0;
        w_ad_out = 8'h00;
        case (r_estado)
            A_SET, A_HLD: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_dir;
            end
            A_STB: begin
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_dir;
            end
            D_SET: begin
                w_cs_n = 1'b0;
                w_a_d  = 1'b1;
            end
            D_STB: begin
                w_cs_n = 1'b0;
                w_rd_n = 1'b0;
                w_a_d  = 1'b1;
            end
            D_HLD: begin
                w_a_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fase     <= '0;
            r_idx      <= 4'd0;
            r_refresco <= '0;
            error_bcd  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_sombra[i] <= 8'h00;
            end
        end else begin
            r_refresco <= w_refresco_fin ? '0 : r_refresco + 1'b1;

            if ((r_estado == A_STB || r_estado == D_STB) && !w_fase_fin) begin
                r_fase <= r_fase + 1'b1;
            end else begin
                r_fase <= '0;
            end

            if (r_estado == ESPERA) begin
                r_idx <= 4'd0;
            end else if (r_estado == D_HLD && r_idx != c_IDX_ULT) begin
                r_idx <= r_idx + 4'd1;
            end

            // Strobes are registered one cycle behind the state, so the last
            // low cycle of rd_n on the pins coincides with D_HLD here.
            if (r_estado == D_HLD) begin
                if (w_bcd_ok) begin
                    r_sombra[r_idx] <= ad_in;
                end else begin
                    error_bcd <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cs_n        <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            a_d         <= 1'b0;
            ad_oe       <= 1'b0;
            ad_out      <= 8'h00;
            ocupado     <= 1'b0;
            dato_valido <= 1'b0;
            seg         <= 8'h00;
            min         <= 8'h00;
            hora        <= 8'h00;
            dia         <= 8'h00;
            mes         <= 8'h00;
            ano         <= 8'h00;
            t_seg       <= 8'h00;
            t_min       <= 8'h00;
            t_hora      <= 8'h00;
        end else begin
            cs_n        <= w_cs_n;
            rd_n        <= w_rd_n;
            wr_n        <= w_wr_n;
            a_d         <= w_a_d;
            ad_oe       <= w_ad_oe;
            ad_out      <= w_ad_out;
            ocupado     <= (r_estado != ESPERA);
            dato_valido <= (r_estado == FIN);
            if (r_estado == FIN) begin
                seg    <= r_sombra[0];
                min    <= r_sombra[1];
                hora   <= r_sombra[2];
                dia    <= r_sombra[3];
                mes    <= r_sombra[4];
                ano    <= r_sombra[5];
                t_seg  <= r_sombra[6];
                t_min  <= r_sombra[7];
                t_hora <= r_sombra[8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_lectura_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_lectura_ctrl
//  Description : Directed bench for rtc_lectura_ctrl with a behavioural RTC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_lectura_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       pausa, leer_ya, pausa2;
    logic [7:0] ad_in, ad_in2, ad_out, ad_out2;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d;
    logic       ad_oe2, cs_n2, rd_n2, wr_n2, a_d2;
    logic [7:0] seg, min, hora, dia, mes, ano, t_seg, t_min, t_hora;
    logic [7:0] seg2, min2, hora2, dia2, mes2, ano2, t_seg2, t_min2, t_hora2;
    logic       dato_valido, error_bcd, ocupado;
    logic       dato_valido2, error_bcd2, ocupado2;

    always #5 CLK = ~CLK;

    rtc_lectura_ctrl dut (
        .CLK(CLK), .RESET(RESET), .pausa(pausa), .leer_ya(leer_ya),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .ano(ano),
        .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora),
        .dato_valido(dato_valido), .error_bcd(error_bcd), .ocupado(ocupado)
    );

    rtc_lectura_ctrl #(.T_FASE(10), .T_REFRESCO(300)) dut2 (
        .CLK(CLK), .RESET(RESET), .pausa(pausa2), .leer_ya(1'b0),
        .ad_in(ad_in2), .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2),
        .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2),
        .seg(seg2), .min(min2), .hora(hora2), .dia(dia2), .mes(mes2), .ano(ano2),
        .t_seg(t_seg2), .t_min(t_min2), .t_hora(t_hora2),
        .dato_valido(dato_valido2), .error_bcd(error_bcd2), .ocupado(ocupado2)
    );

    // Behavioural RTC: latches the address on a write strobe, returns the byte.
    logic [7:0] rtc [0:8];
    logic [7:0] addr_q;
    logic [7:0] addr_tab [0:8];

    always_ff @(posedge CLK) begin
        if (!wr_n && !cs_n && ad_oe && !a_d) addr_q <= ad_out;
    end

    always_comb begin
        case (addr_q)
            8'h21:   ad_in = rtc[0];
            8'h22:   ad_in = rtc[1];
            8'h23:   ad_in = rtc[2];
            8'h24:   ad_in = rtc[3];
            8'h25:   ad_in = rtc[4];
            8'h26:   ad_in = rtc[5];
            8'h41:   ad_in = rtc[6];
            8'h42:   ad_in = rtc[7];
            8'h43:   ad_in = rtc[8];
            default: ad_in = 8'hFF;
        endcase
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, dv_cnt = 0, viol2 = 0;
    int wr_len = 0, rd_len = 0, wr_cnt = 0, post_wr = 0;
    int c0, at, d0, found;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step, sampled at the falling edge, with bus-protocol checks.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (dato_valido) dv_cnt++;
        if (pausa2 && (!cs_n2 || ocupado2)) viol2++;
        if (!RESET) begin
            wr_len = 0; rd_len = 0; wr_cnt = 0; post_wr = 0;
        end else begin
            if (!ocupado) wr_cnt = 0;
            if (!wr_n || !rd_n) chk(32'(wr_n | rd_n), 32'd1, "rd_wr_solape");
            if (!rd_n) chk(32'(ad_oe), 32'd0, "oe_en_lectura");
            if (!wr_n) begin
                wr_len++;
                chk(32'(ad_out), 32'(addr_tab[(wr_cnt > 8) ? 8 : wr_cnt]), "ad_out_wr");
            end else if (wr_len != 0) begin
                chk(32'(wr_len), 32'd10, "ancho_wr");
                chk(32'(cs_n), 32'd0, "cs_a_hld");
                wr_len = 0; wr_cnt++; post_wr = 1;
            end else if (post_wr == 1) begin
                chk(32'(cs_n), 32'd1, "cs_gap");
                chk(32'(ad_oe), 32'd0, "oe_gap");
                post_wr = 0;
            end
            if (!rd_n) rd_len++;
            else if (rd_len != 0) begin
                chk(32'(rd_len), 32'd10, "ancho_rd");
                rd_len = 0;
            end
        end
    endtask

    task automatic pulse_leer();
        leer_ya = 1'b1;
        tick();
        leer_ya = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_dv(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (dato_valido) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk(32'd0, 32'd1, "timeout_dv");
    endtask

    task automatic chk_snap(input logic [71:0] e, input string tag);
        chk(32'(seg),    32'(e[71:64]), {tag, "_seg"});
        chk(32'(min),    32'(e[63:56]), {tag, "_min"});
        chk(32'(hora),   32'(e[55:48]), {tag, "_hora"});
        chk(32'(dia),    32'(e[47:40]), {tag, "_dia"});
        chk(32'(mes),    32'(e[39:32]), {tag, "_mes"});
        chk(32'(ano),    32'(e[31:24]), {tag, "_ano"});
        chk(32'(t_seg),  32'(e[23:16]), {tag, "_tseg"});
        chk(32'(t_min),  32'(e[15:8]),  {tag, "_tmin"});
        chk(32'(t_hora), 32'(e[7:0]),   {tag, "_thora"});
    endtask

    task automatic frame(input logic [71:0] d, input logic [71:0] e,
                         input logic err, input string tag);
        for (int i = 0; i < 9; i++) rtc[i] = d[71 - 8*i -: 8];
        pulse_leer();
        wait_dv(400, at);
        chk(32'(at - c0), 32'd226, {tag, "_latencia"});
        chk_snap(e, tag);
        chk(32'(error_bcd), 32'(err), {tag, "_error_bcd"});
        tick();
        chk(32'(dato_valido), 32'd0, {tag, "_dv_un_ciclo"});
        chk(32'(ocupado), 32'd0, {tag, "_ocupado_fin"});
    endtask

    initial begin
        addr_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        rtc      = '{default: 8'h00};
        RESET = 1'b0; pausa = 1'b0; leer_ya = 1'b0; pausa2 = 1'b1; ad_in2 = 8'h11;
        repeat (3) tick();
        chk(32'({cs_n, rd_n, wr_n, a_d, ad_oe}), 32'b11100, "reset_bus");
        chk(32'(ad_out), 32'd0, "reset_ad_out");
        chk(32'({dato_valido, error_bcd, ocupado}), 32'd0, "reset_flags");
        chk_snap(72'd0, "reset");
        RESET = 1'b1;
        repeat (2) tick();

        // First request: A_SET outputs appear one edge after the sampling edge.
        for (int i = 0; i < 9; i++) rtc[i] = 8'h00;
        rtc = '{8'h45, 8'h30, 8'h12, 8'h22, 8'h09, 8'h16, 8'h05, 8'h10, 8'h01};
        pulse_leer();
        chk(32'({ocupado, cs_n}), 32'b01, "leer_ya_lat_n");
        tick();
        chk(32'({ocupado, cs_n, ad_oe, a_d}), 32'b1010, "a_set_salidas");
        chk(32'(ad_out), 32'h21, "a_set_dir");
        wait_dv(400, at);
        chk(32'(at - c0), 32'd226, "f1_latencia");
        chk_snap(72'h45_30_12_22_09_16_05_10_01, "f1");
        chk(32'(error_bcd), 32'd0, "f1_error_bcd");
        tick();
        chk(32'(dato_valido), 32'd0, "f1_dv_un_ciclo");

        frame(72'h46_5A_13_23_10_17_06_11_02, 72'h46_30_13_23_10_17_06_11_02, 1'b1, "f2_bcd_malo");
        frame(72'h47_31_14_24_11_18_07_12_03, 72'h47_31_14_24_11_18_07_12_03, 1'b1, "f3_limpio");

        // pausa raised mid-frame lets the frame finish.
        rtc = '{8'h48, 8'h32, 8'h15, 8'h25, 8'h12, 8'h19, 8'h08, 8'h13, 8'h04};
        pulse_leer();
        repeat (50) tick();
        pausa = 1'b1;
        wait_dv(400, at);
        chk(32'(at - c0), 32'd226, "pausa_mid_latencia");
        chk_snap(72'h48_32_15_25_12_19_08_13_04, "pausa_mid");

        // pausa held: request ignored.
        repeat (3) tick();
        pulse_leer();
        d0 = dv_cnt;
        repeat (300) tick();
        chk(32'(dv_cnt - d0), 32'd0, "pausa_sin_dv");
        chk(32'(ocupado), 32'd0, "pausa_ocupado");
        pausa = 1'b0;

        // Second request while busy is dropped.
        rtc = '{8'h50, 8'h33, 8'h16, 8'h26, 8'h01, 8'h20, 8'h09, 8'h14, 8'h05};
        pulse_leer();
        d0 = dv_cnt;
        repeat (29) tick();
        pulse_leer();
        repeat (600) tick();
        chk(32'(dv_cnt - d0), 32'd1, "ocupado_un_dv");
        chk_snap(72'h50_33_16_26_01_20_09_14_05, "ocupado");

        // Reset mid-frame aborts at once.
        rtc = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h23};
        pulse_leer();
        repeat (99) tick();
        RESET = 1'b0;
        #1;
        chk(32'({cs_n, rd_n, wr_n, ad_oe, ocupado, dato_valido}), 32'b111000, "reset_mid_bus");
        chk(32'(error_bcd), 32'd0, "reset_mid_error");
        chk_snap(72'd0, "reset_mid");
        repeat (3) tick();
        RESET = 1'b1;
        d0 = dv_cnt;
        repeat (300) tick();
        chk(32'(dv_cnt - d0), 32'd0, "reset_mid_sin_dv");
        frame(72'h59_59_23_31_12_99_59_59_23, 72'h59_59_23_31_12_99_59_59_23, 1'b0, "post_reset");

        // Second instance: pausa held for the whole run so far, then released.
        chk(32'(viol2), 32'd0, "pausa2_sin_trama");
        pausa2 = 1'b0;
        found = 0;
        for (int i = 0; i < 310; i++) begin
            tick();
            if (ocupado2) begin
                found = 1;
                break;
            end
        end
        chk(32'(found), 32'd1, "pausa2_arranque_auto");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
